// File: rtl/matmul_datapath_pkg.sv
// Shared sizing, host bank-select encodings and the radix-4 partial-product helper
// for the matrix-multiply datapath.
package matmul_datapath_pkg;

    localparam int DIM  = 4;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int ACCW = 2 * DW + $clog2(DIM);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_M1   = 2'd1,
        SEL_M2   = 2'd2,
        SEL_M3   = 2'd3
    } bank_sel_e;

    // One radix-4 digit of b times a, already shifted into its final weight.
    function automatic logic [ACCW-1:0] partial_product(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [1:0]    sc
    );
        logic [1:0]      digit;
        logic [ACCW-1:0] prod;
        digit = b[{sc, 1'b0} +: 2];
        prod  = ACCW'(a) * ACCW'(digit);
        return prod << {sc, 1'b0};
    endfunction

endpackage

// File: rtl/matmul_datapath_sp_bank.sv
// Single-port synchronous RAM: read-before-write, registered read data that holds
// its value until the next read. Contents are not reset.
module sp_bank #(
    parameter int WIDTH = 8,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [2**AW];
    logic [WIDTH-1:0] rdata_r;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register; the nonblocking write above makes a same-edge read see old data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_r <= {WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/matmul_datapath.sv
// Datapath behind the matrix-multiply controller: three operand/result banks with
// host access arbitration and a radix-4 shift-add MAC.
module matmul_datapath
    import matmul_datapath_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            m1EN,
    input  logic            m2EN,
    input  logic            m3EN,
    input  logic            m1rEN,
    input  logic            m2rEN,
    input  logic            m3rEN,
    input  logic            m1wEN,
    input  logic            m2wEN,
    input  logic            m3wEN,
    input  logic [AW-1:0]   addr1,
    input  logic [AW-1:0]   addr2,
    input  logic [AW-1:0]   addr3,
    input  logic            mult_ld,
    input  logic [1:0]      shift_cnt,
    input  logic            mult_rst,
    input  logic            host_we,
    input  logic [1:0]      host_sel,
    input  logic [AW-1:0]   host_addr,
    input  logic [ACCW-1:0] host_din,
    input  logic            host_re,
    output logic [ACCW-1:0] host_dout,
    output logic            host_nack,
    output logic [ACCW-1:0] acc
);

    logic [2:0]      ctrl_en_s;
    logic [2:0]      host_hit_s;
    logic [2:0]      host_ok_s;
    logic [DW-1:0]   b1_rdata_s;
    logic [DW-1:0]   b2_rdata_s;
    logic [ACCW-1:0] b3_rdata_s;
    logic [DW-1:0]   rd1_s;
    logic [DW-1:0]   rd2_s;
    logic [ACCW-1:0] sel_dout_s;
    logic [ACCW-1:0] host_dout_s;

    logic [1:0]      ctrl_rd_q_r;
    logic            host_rd_q_r;
    bank_sel_e       host_sel_q_r;
    logic            nack_r;
    logic [DW-1:0]   rd1_hold_r;
    logic [DW-1:0]   rd2_hold_r;
    logic [ACCW-1:0] dout_hold_r;
    logic [DW-1:0]   op_a_r;
    logic [DW-1:0]   op_b_r;
    logic            op_vld_r;
    logic [ACCW-1:0] acc_r;

    // The controller owns a bank whenever it holds that bank's EN; the host gets the rest.
    assign ctrl_en_s     = {m3EN, m2EN, m1EN};
    assign host_hit_s[0] = (host_we || host_re) && (host_sel == SEL_M1);
    assign host_hit_s[1] = (host_we || host_re) && (host_sel == SEL_M2);
    assign host_hit_s[2] = (host_we || host_re) && (host_sel == SEL_M3);
    assign host_ok_s     = host_hit_s & ~ctrl_en_s;

    sp_bank #(.WIDTH(DW), .AW(AW)) u_m1 (
        .clk   (clk),
        .rst   (rst),
        .we    (m1EN ? m1wEN : (host_ok_s[0] && host_we)),
        .re    (m1EN ? m1rEN : (host_ok_s[0] && host_re)),
        .addr  (m1EN ? addr1 : host_addr),
        .wdata (host_din[DW-1:0]),
        .rdata (b1_rdata_s)
    );

    sp_bank #(.WIDTH(DW), .AW(AW)) u_m2 (
        .clk   (clk),
        .rst   (rst),
        .we    (m2EN ? m2wEN : (host_ok_s[1] && host_we)),
        .re    (m2EN ? m2rEN : (host_ok_s[1] && host_re)),
        .addr  (m2EN ? addr2 : host_addr),
        .wdata (host_din[DW-1:0]),
        .rdata (b2_rdata_s)
    );

    sp_bank #(.WIDTH(ACCW), .AW(AW)) u_m3 (
        .clk   (clk),
        .rst   (rst),
        .we    (m3EN ? m3wEN : (host_ok_s[2] && host_we)),
        .re    (m3EN ? m3rEN : (host_ok_s[2] && host_re)),
        .addr  (m3EN ? addr3 : host_addr),
        .wdata (m3EN ? acc_r : host_din),
        .rdata (b3_rdata_s)
    );

    // Each bank's read register is shared, so rd1/rd2/host_dout follow it only after
    // their own read and otherwise replay their last value.
    assign rd1_s = ctrl_rd_q_r[0] ? b1_rdata_s : rd1_hold_r;
    assign rd2_s = ctrl_rd_q_r[1] ? b2_rdata_s : rd2_hold_r;

    // Select the bank the host read last cycle.
    always_comb begin
        sel_dout_s = {ACCW{1'b0}};
        case (host_sel_q_r)
            SEL_M1:  sel_dout_s = {{(ACCW-DW){1'b0}}, b1_rdata_s};
            SEL_M2:  sel_dout_s = {{(ACCW-DW){1'b0}}, b2_rdata_s};
            SEL_M3:  sel_dout_s = b3_rdata_s;
            default: sel_dout_s = {ACCW{1'b0}};
        endcase
        if (host_rd_q_r) begin
            host_dout_s = sel_dout_s;
        end else begin
            host_dout_s = dout_hold_r;
        end
    end

    // Read-ownership tracking, hold registers and collision reporting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_rd_q_r  <= 2'b00;
            host_rd_q_r  <= 1'b0;
            host_sel_q_r <= SEL_NONE;
            nack_r       <= 1'b0;
            rd1_hold_r   <= {DW{1'b0}};
            rd2_hold_r   <= {DW{1'b0}};
            dout_hold_r  <= {ACCW{1'b0}};
        end else begin
            ctrl_rd_q_r  <= {m2EN && m2rEN, m1EN && m1rEN};
            host_rd_q_r  <= host_re && (host_ok_s != 3'b000);
            host_sel_q_r <= bank_sel_e'(host_sel);
            nack_r       <= (host_hit_s & ctrl_en_s) != 3'b000;
            rd1_hold_r   <= rd1_s;
            rd2_hold_r   <= rd2_s;
            dout_hold_r  <= host_dout_s;
        end
    end

    // Radix-4 shift-add MAC: clear beats load, load beats accumulate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a_r   <= {DW{1'b0}};
            op_b_r   <= {DW{1'b0}};
            op_vld_r <= 1'b0;
            acc_r    <= {ACCW{1'b0}};
        end else if (mult_rst) begin
            op_vld_r <= 1'b0;
            acc_r    <= {ACCW{1'b0}};
        end else if (mult_ld) begin
            op_a_r   <= rd1_s;
            op_b_r   <= rd2_s;
            op_vld_r <= 1'b1;
        end else if (op_vld_r) begin
            acc_r    <= acc_r + partial_product(op_a_r, op_b_r, shift_cnt);
        end
    end

    assign host_dout = host_dout_s;
    assign host_nack = nack_r;
    assign acc       = acc_r;

endmodule

// File: tb/tb_matmul_datapath.sv
// Directed bench for matmul_datapath: host reads are checked by a scoreboard monitor,
// MAC, collision and reset behaviour by direct comparisons against hand-computed values.
module tb_matmul_datapath;
    import matmul_datapath_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            m1EN, m2EN, m3EN, m1rEN, m2rEN, m3rEN, m1wEN, m2wEN, m3wEN;
    logic [AW-1:0]   addr1, addr2, addr3;
    logic            mult_ld, mult_rst;
    logic [1:0]      shift_cnt;
    logic            host_we, host_re;
    logic [1:0]      host_sel;
    logic [AW-1:0]   host_addr;
    logic [ACCW-1:0] host_din;
    logic [ACCW-1:0] host_dout;
    logic            host_nack;
    logic [ACCW-1:0] acc;

    logic            rd_expect;
    logic [ACCW-1:0] exp_q[$];
    int              total = 0;
    int              bad   = 0;

    matmul_datapath dut (
        .clk(clk), .rst(rst),
        .m1EN(m1EN), .m2EN(m2EN), .m3EN(m3EN),
        .m1rEN(m1rEN), .m2rEN(m2rEN), .m3rEN(m3rEN),
        .m1wEN(m1wEN), .m2wEN(m2wEN), .m3wEN(m3wEN),
        .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .mult_ld(mult_ld), .shift_cnt(shift_cnt), .mult_rst(mult_rst),
        .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr),
        .host_din(host_din), .host_re(host_re),
        .host_dout(host_dout), .host_nack(host_nack), .acc(acc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [ACCW-1:0] act, input logic [ACCW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a host read accepted at this edge presents data just after it.
    always @(posedge clk) begin
        if (rd_expect) begin
            #1;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL host_rd: got %0d with empty scoreboard", host_dout);
            end else begin
                logic [ACCW-1:0] e;
                e = exp_q.pop_front();
                if (host_dout !== e) begin
                    bad++;
                    $display("FAIL host_rd: got %0d expected %0d", host_dout, e);
                end
            end
        end
    end

    task automatic clr();
        {m1EN, m2EN, m3EN, m1rEN, m2rEN, m3rEN, m1wEN, m2wEN, m3wEN} = 9'd0;
        addr1 = 8'd0; addr2 = 8'd0; addr3 = 8'd0;
        mult_ld = 1'b0; mult_rst = 1'b0; shift_cnt = 2'd0;
        host_we = 1'b0; host_re = 1'b0; host_sel = 2'd0;
        host_addr = 8'd0; host_din = 18'd0; rd_expect = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic hw(input logic [1:0] s, input logic [AW-1:0] a, input logic [ACCW-1:0] d);
        host_we = 1'b1; host_sel = s; host_addr = a; host_din = d;
        tick();
        clr();
    endtask

    task automatic hr(input logic [1:0] s, input logic [AW-1:0] a, input logic [ACCW-1:0] e);
        host_re = 1'b1; host_sel = s; host_addr = a; rd_expect = 1'b1;
        exp_q.push_back(e);
        tick();
        clr();
    endtask

    // Controller reads operand pair at address a, clearing the MAC in the same cycle.
    task automatic load_pair(input logic [AW-1:0] a);
        mult_rst = 1'b1;
        m1EN = 1'b1; m1rEN = 1'b1; addr1 = a;
        m2EN = 1'b1; m2rEN = 1'b1; addr2 = a;
        tick();
        clr();
        mult_ld = 1'b1;
        tick();
        clr();
    endtask

    task automatic steps(input string name, input logic [ACCW-1:0] e0, input logic [ACCW-1:0] e1,
                         input logic [ACCW-1:0] e2, input logic [ACCW-1:0] e3);
        logic [ACCW-1:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        for (int k = 0; k < 4; k++) begin
            shift_cnt = 2'(k);
            tick();
            check($sformatf("%s_step%0d", name, k), acc, ev[k]);
        end
        clr();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        clr();
        repeat (2) tick();
        check("rst_acc", acc, 18'd0);
        check("rst_dout", host_dout, 18'd0);
        check("rst_nack", {17'd0, host_nack}, 18'd0);
        rst = 1'b1;
        tick();

        hw(2'd1, 8'd0, 18'd7);   hw(2'd2, 8'd0, 18'd9);
        hw(2'd1, 8'd1, 18'd255); hw(2'd2, 8'd1, 18'd255);
        hw(2'd1, 8'd4, 18'd20);  hw(2'd2, 8'd4, 18'd233);

        // 255*255 twice: the second product stacks on the first without wrapping
        load_pair(8'd1);
        check("ld_acc_hold", acc, 18'd0);
        steps("ff_a", 18'd765, 18'd3825, 18'd16065, 18'd65025);
        mult_ld = 1'b1;
        tick();
        clr();
        check("reload_acc_hold", acc, 18'd65025);
        steps("ff_b", 18'd65790, 18'd68850, 18'd81090, 18'd130050);

        // 7*9
        load_pair(8'd0);
        steps("p63", 18'd7, 18'd63, 18'd63, 18'd63);

        // M3 write captures pre-step acc while the step adds 7
        shift_cnt = 2'd0; m3EN = 1'b1; m3wEN = 1'b1; addr3 = 8'd5;
        tick();
        clr();
        check("m3wr_step_acc", acc, 18'd70);

        // clear wins over load; op_vld must drop
        mult_rst = 1'b1; mult_ld = 1'b1;
        tick();
        clr();
        check("rst_ld_acc", acc, 18'd0);
        shift_cnt = 2'd1;
        tick();
        clr();
        check("no_acc_after_rst_ld", acc, 18'd0);
        hr(2'd3, 8'd5, 18'd63);

        // host collision on M2
        hw(2'd2, 8'd2, 18'h11);
        m2EN = 1'b1; host_we = 1'b1; host_sel = 2'd2; host_addr = 8'd2; host_din = 18'h55;
        tick();
        clr();
        check("nack_pulse", {17'd0, host_nack}, 18'd1);
        tick();
        check("nack_clear", {17'd0, host_nack}, 18'd0);
        hr(2'd2, 8'd2, 18'h11);
        hw(2'd2, 8'd2, 18'h55);
        check("no_nack_free", {17'd0, host_nack}, 18'd0);
        hr(2'd2, 8'd2, 18'h55);

        // dropped host read leaves host_dout alone
        m1EN = 1'b1; host_re = 1'b1; host_sel = 2'd1; host_addr = 8'd0;
        tick();
        clr();
        check("rd_nack", {17'd0, host_nack}, 18'd1);
        check("rd_nack_dout", host_dout, 18'h55);

        // host sel 0 ignored
        host_we = 1'b1; host_re = 1'b1; host_sel = 2'd0; m1EN = 1'b1; m2EN = 1'b1; m3EN = 1'b1;
        tick();
        clr();
        check("sel0_no_nack", {17'd0, host_nack}, 18'd0);

        // host read-before-write
        hw(2'd1, 8'd3, 18'h22);
        host_we = 1'b1; host_re = 1'b1; host_sel = 2'd1; host_addr = 8'd3; host_din = 18'h33;
        rd_expect = 1'b1;
        exp_q.push_back(18'h22);
        tick();
        clr();
        hr(2'd1, 8'd3, 18'h33);

        // 20*233 = 0x1234, then asynchronous reset mid-run
        load_pair(8'd4);
        steps("p1234", 18'd20, 18'd180, 18'd820, 18'h1234);
        shift_cnt = 2'd1;
        #1 rst = 1'b0;
        #1;
        check("arst_acc", acc, 18'd0);
        check("arst_dout", host_dout, 18'd0);
        check("arst_rd1", {10'd0, dut.rd1_s}, 18'd0);
        check("arst_rd2", {10'd0, dut.rd2_s}, 18'd0);
        clr();
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_acc", acc, 18'd0);
        hr(2'd1, 8'd4, 18'd20);
        hr(2'd2, 8'd4, 18'd233);
        repeat (2) tick();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
